dsp_addsub_seq: RTL and testbench



---
 rtl/dsp_addsub_pkg.sv | 12 +
 rtl/dsp_addsub_lane.sv | 21 ++
 rtl/dsp_addsub_seq.sv | 124 ++++++++++++
 tb/tb_dsp_addsub_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_addsub_pkg.sv
// rtl/dsp_addsub_pkg.sv - shared state encoding and lane width for the sequential add/sub
package dsp_addsub_pkg;

    localparam int LANE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dsp_addsub_lane.sv
// rtl/dsp_addsub_lane.sv - combinational LANE-bit adder with carry-in, carry-out and MSB carry-in
module dsp_addsub_lane #(
    parameter int LANE = 16
) (
    input  logic [LANE-1:0] a,
    input  logic [LANE-1:0] b,
    input  logic            cin,
    output logic [LANE-1:0] sum,
    output logic            cout,
    output logic            msb_cin
);

    logic [LANE:0] full;

    assign full    = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, cin};
    assign sum     = full[LANE-1:0];
    assign cout    = full[LANE];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out of the sum.
    assign msb_cin = a[LANE-1] ^ b[LANE-1] ^ full[LANE-1];

endmodule

// File: rtl/dsp_addsub_seq.sv
// rtl/dsp_addsub_seq.sv - lane-serial add/sub, one LANE slice per cycle; DSP_ADDSUB_FLAGS_EN adds carry_out/overflow
module dsp_addsub_seq
    import dsp_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANE  = LANE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DSP_ADDSUB_FLAGS_EN
    output logic             carry_out,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int N     = WIDTH / LANE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic [CNT_W-1:0]  lane_k;
    logic              last_lane;
    logic [LANE-1:0]   lane_sum;
    logic              lane_cout;
    logic              lane_msb_cin;
    logic [WIDTH-1:0]  next_result;

    dsp_addsub_lane #(.LANE(LANE)) u_lane (
        .a       (a_sh[LANE-1:0]),
        .b       (b_sh[LANE-1:0]),
        .cin     (carry),
        .sum     (lane_sum),
        .cout    (lane_cout),
        .msb_cin (lane_msb_cin)
    );

    assign last_lane = (lane_k == CNT_W'(N - 1));

    // Operands shift down one lane per cycle and the result fills from the top,
    // so after N lanes lane 0 has landed in result[LANE-1:0].
    generate
        if (N == 1) begin : g_single
            assign next_result = lane_sum;
        end else begin : g_multi
            assign next_result = {lane_sum, result[WIDTH-1:LANE]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_lane) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            lane_k <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && in_valid) begin
                // Subtraction is a + ~b + 1: invert b here and seed the carry with sub.
                a_sh   <= a;
                b_sh   <= sub ? ~b : b;
                carry  <= sub;
                lane_k <= '0;
            end else if (state == BUSY) begin
                a_sh   <= a_sh >> LANE;
                b_sh   <= b_sh >> LANE;
                carry  <= lane_cout;
                result <= next_result;
                if (!last_lane) lane_k <= lane_k + 1'b1;
            end
        end
    end

`ifdef DSP_ADDSUB_FLAGS_EN
    logic msb_cin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_cin_q <= 1'b0;
        end else if (state == BUSY) begin
            msb_cin_q <= lane_msb_cin;
        end
    end

    assign carry_out = carry;
    assign overflow  = msb_cin_q ^ carry;
`else
    logic msb_cin_unused;
    assign msb_cin_unused = lane_msb_cin;
`endif

endmodule

// File: tb/tb_dsp_addsub_seq.sv
// tb/tb_dsp_addsub_seq.sv - scoreboard bench for dsp_addsub_seq at WIDTH 32, 64 and 16 (N=1)
module tb_dsp_addsub_seq;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv32 = 0, ir32, s32 = 0, ov32, ordy32 = 0, co32, of32;
    logic [31:0] a32 = 0, b32 = 0, res32;
    logic        iv64 = 0, ir64, s64 = 0, ov64, ordy64 = 0, co64, of64;
    logic [63:0] a64 = 0, b64 = 0, res64;
    logic        iv16 = 0, ir16, s16 = 0, ov16, ordy16 = 0, co16, of16;
    logic [15:0] a16 = 0, b16 = 0, res16;

    int checks   = 0;
    int failures = 0;
    exp_t q32[$];
    exp_t q64[$];
    exp_t q16[$];

    dsp_addsub_seq #(.WIDTH(32), .LANE(16)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(s32),
        .out_valid(ov32), .out_ready(ordy32),
`ifdef DSP_ADDSUB_FLAGS_EN
        .carry_out(co32), .overflow(of32),
`endif
        .result(res32)
    );

    dsp_addsub_seq #(.WIDTH(64), .LANE(16)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .sub(s64),
        .out_valid(ov64), .out_ready(ordy64),
`ifdef DSP_ADDSUB_FLAGS_EN
        .carry_out(co64), .overflow(of64),
`endif
        .result(res64)
    );

    dsp_addsub_seq #(.WIDTH(16), .LANE(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(s16),
        .out_valid(ov16), .out_ready(ordy16),
`ifdef DSP_ADDSUB_FLAGS_EN
        .carry_out(co16), .overflow(of16),
`endif
        .result(res16)
    );

`ifndef DSP_ADDSUB_FLAGS_EN
    assign co32 = 1'b0; assign of32 = 1'b0;
    assign co64 = 1'b0; assign of64 = 1'b0;
    assign co16 = 1'b0; assign of16 = 1'b0;
`endif

    function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y, input logic s);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] yy;
        logic [64:0] full;
        mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        yy     = (s ? ~y : y) & mask;
        full   = {1'b0, x & mask} + {1'b0, yy} + {64'd0, s};
        e.res  = full[63:0] & mask;
        e.c    = full[w];
        e.ov   = (x[w-1] == yy[w-1]) && (e.res[w-1] != x[w-1]);
        return e;
    endfunction

    // Called at a negedge; returns the number of rising edges from transfer to out_valid.
    task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s, output int lat);
        a32 = x; b32 = y; s32 = s; iv32 = 1'b1;
        @(posedge clk); @(negedge clk);
        iv32 = 1'b0;
        lat = 0;
        while (ov32 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s, output int lat);
        a16 = x; b16 = y; s16 = s; iv16 = 1'b1;
        @(posedge clk); @(negedge clk);
        iv16 = 1'b0;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release32();
        ordy32 = 1'b1;
        @(negedge clk);
        ordy32 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (ir32 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", ir32); end
        checks++; if (ov32 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", ov32); end
        checks++; if (res32 !== 32'h0) begin failures++; $display("FAIL reset_result32 got=%h want=0", res32); end
        checks++; if (res64 !== 64'h0 || ov64 !== 1'b0) begin failures++; $display("FAIL reset_64 res=%h ov=%b want 0/0", res64, ov64); end
        rst = 1'b0;
    endtask

    // Transfer on the very first edge after reset release.
    task automatic test_carry();
        int lat;
        exp_t e;
        q32.push_back('{res: 64'h0, c: 1'b1, ov: 1'b0});
        op32(32'hFFFF_FFFF, 32'h1, 1'b0, lat);
        e = q32.pop_front();
        checks++; if (lat !== 2) begin failures++; $display("FAIL carry_latency got=%0d want=2", lat); end
        checks++; if (res32 !== e.res[31:0]) begin failures++; $display("FAIL carry_result got=%h want=%h", res32, e.res[31:0]); end
`ifdef DSP_ADDSUB_FLAGS_EN
        checks++; if (co32 !== e.c || of32 !== e.ov) begin failures++; $display("FAIL carry_flags got=%b%b want=%b%b", co32, of32, e.c, e.ov); end
`endif
        release32();
    endtask

    task automatic test_sub();
        int lat;
        exp_t e;
        q32.push_back('{res: 64'hFFFF_FFFE, c: 1'b0, ov: 1'b0});
        q32.push_back('{res: 64'h7FFF_FFFF, c: 1'b1, ov: 1'b1});
        op32(32'd5, 32'd7, 1'b1, lat);
        e = q32.pop_front();
        checks++; if (res32 !== e.res[31:0]) begin failures++; $display("FAIL sub_5_7 got=%h want=%h", res32, e.res[31:0]); end
`ifdef DSP_ADDSUB_FLAGS_EN
        checks++; if (co32 !== e.c || of32 !== e.ov) begin failures++; $display("FAIL sub_5_7_flags got=%b%b want=%b%b", co32, of32, e.c, e.ov); end
`endif
        release32();
        op32(32'h8000_0000, 32'd1, 1'b1, lat);
        e = q32.pop_front();
        checks++; if (res32 !== e.res[31:0]) begin failures++; $display("FAIL sub_min got=%h want=%h", res32, e.res[31:0]); end
`ifdef DSP_ADDSUB_FLAGS_EN
        checks++; if (of32 !== e.ov) begin failures++; $display("FAIL sub_min_overflow got=%b want=%b", of32, e.ov); end
`endif
        release32();
    endtask

    task automatic test_hold();
        int lat;
        exp_t e;
        q32.push_back('{res: 64'h8000_0000, c: 1'b0, ov: 1'b1});
        op32(32'h7FFF_FFFF, 32'd1, 1'b0, lat);
        e = q32.pop_front();
        // Offer a new operand throughout DONE; it must not be taken.
        a32 = 32'd9; b32 = 32'd9; iv32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ov32 !== 1'b1 || res32 !== e.res[31:0] || ir32 !== 1'b0) begin
                failures++; $display("FAIL hold_stable cyc=%0d ov=%b ir=%b res=%h want ov=1 ir=0 res=%h", i, ov32, ir32, res32, e.res[31:0]);
            end
`ifdef DSP_ADDSUB_FLAGS_EN
            checks++; if (of32 !== e.ov) begin failures++; $display("FAIL hold_overflow cyc=%0d got=%b want=%b", i, of32, e.ov); end
`endif
            @(negedge clk);
        end
        ordy32 = 1'b1;
        @(negedge clk);
        ordy32 = 1'b0;
        checks++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin failures++; $display("FAIL hold_release ov=%b ir=%b want ov=0 ir=1", ov32, ir32); end
        iv32 = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat;
        bit saw_valid;
        exp_t e;
        a32 = 32'h1234_5678; b32 = 32'h1; s32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); @(negedge clk);
        iv32 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (ir32 !== 1'b1 || res32 !== 32'h0) begin failures++; $display("FAIL abort_async ir=%b res=%h want ir=1 res=0", ir32, res32); end
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov32 === 1'b1) saw_valid = 1;
        end
        checks++; if (saw_valid) begin failures++; $display("FAIL abort_no_output got=1 want=0"); end
        checks++; if (ir32 !== 1'b1 || res32 !== 32'h0) begin failures++; $display("FAIL abort_idle ir=%b res=%h want ir=1 res=0", ir32, res32); end
        q32.push_back(model(32, 64'd3, 64'd4, 1'b0));
        op32(32'd3, 32'd4, 1'b0, lat);
        e = q32.pop_front();
        checks++; if (res32 !== 32'd7 || res32 !== e.res[31:0]) begin failures++; $display("FAIL abort_then_3p4 got=%h want=%h", res32, e.res[31:0]); end
        release32();
    endtask

    task automatic test_width64();
        int lat;
        exp_t e;
        q64.push_back('{res: 64'h0000_0001_0000_0000, c: 1'b0, ov: 1'b0});
        a64 = 64'h0000_0000_FFFF_FFFF; b64 = 64'h1; s64 = 1'b0; iv64 = 1'b1;
        @(posedge clk); @(negedge clk);
        // Pulse a different operand during BUSY.
        a64 = 64'hDEAD_BEEF_0000_0000; b64 = 64'h5; s64 = 1'b1;
        lat = 0;
        @(negedge clk); lat++;
        iv64 = 1'b0;
        while (ov64 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = q64.pop_front();
        checks++; if (lat !== 4) begin failures++; $display("FAIL w64_latency got=%0d want=4", lat); end
        checks++; if (res64 !== e.res) begin failures++; $display("FAIL w64_result got=%h want=%h", res64, e.res); end
`ifdef DSP_ADDSUB_FLAGS_EN
        checks++; if (co64 !== e.c || of64 !== e.ov) begin failures++; $display("FAIL w64_flags got=%b%b want=%b%b", co64, of64, e.c, e.ov); end
`endif
        ordy64 = 1'b1;
        @(negedge clk);
        ordy64 = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (ov64 !== 1'b0 || ir64 !== 1'b1) begin failures++; $display("FAIL w64_ignored_pulse ov=%b ir=%b want ov=0 ir=1", ov64, ir64); end
    endtask

    task automatic test_n1();
        int lat;
        exp_t e;
        q16.push_back('{res: 64'h0, c: 1'b1, ov: 1'b0});
        q16.push_back('{res: 64'h7FFF, c: 1'b1, ov: 1'b1});
        op16(16'hFFFF, 16'h1, 1'b0, lat);
        e = q16.pop_front();
        checks++; if (lat !== 1) begin failures++; $display("FAIL n1_latency got=%0d want=1", lat); end
        checks++; if (res16 !== e.res[15:0]) begin failures++; $display("FAIL n1_wrap got=%h want=%h", res16, e.res[15:0]); end
        ordy16 = 1'b1; @(negedge clk); ordy16 = 1'b0;
        op16(16'h8000, 16'h1, 1'b1, lat);
        e = q16.pop_front();
        checks++; if (res16 !== e.res[15:0] || lat !== 1) begin failures++; $display("FAIL n1_sub got=%h lat=%0d want=%h lat=1", res16, lat, e.res[15:0]); end
`ifdef DSP_ADDSUB_FLAGS_EN
        checks++; if (co16 !== e.c || of16 !== e.ov) begin failures++; $display("FAIL n1_flags got=%b%b want=%b%b", co16, of16, e.c, e.ov); end
`endif
        ordy16 = 1'b1; @(negedge clk); ordy16 = 1'b0;
    endtask

    task automatic test_random32();
        int lat;
        exp_t e;
        logic [31:0] x, y;
        logic s;
        for (int i = 0; i < 10; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
            if (i == 0) begin x = 32'h0; y = 32'h0; s = 1'b1; end
            q32.push_back(model(32, {32'd0, x}, {32'd0, y}, s));
            op32(x, y, s, lat);
            e = q32.pop_front();
            checks++;
            if (res32 !== e.res[31:0] || lat !== 2) begin
                failures++; $display("FAIL rand_%0d a=%h b=%h sub=%b got=%h lat=%0d want=%h lat=2", i, x, y, s, res32, lat, e.res[31:0]);
            end
`ifdef DSP_ADDSUB_FLAGS_EN
            checks++; if (co32 !== e.c || of32 !== e.ov) begin failures++; $display("FAIL rand_flags_%0d got=%b%b want=%b%b", i, co32, of32, e.c, e.ov); end
`endif
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release32();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_carry();
        test_sub();
        test_hold();
        test_reset_abort();
        test_width64();
        test_n1();
        test_random32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
